// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller and its result FIFO.
//   FflagsW     : width of the IEEE exception flag field carried with every result
//   fpu_state_e : issue FSM states (StIdle accepts ops, StDivRun waits on the div unit)
package fpu_issue_ctrl_pkg;

  localparam int unsigned FflagsW = 5;

  typedef enum logic [0:0] {
    StIdle,
    StDivRun
  } fpu_state_e;

endpackage

// File: rtl/fpu_res_fifo.sv
// Result FIFO for the FPU issue controller.
// Storage is a register array; the head entry is read straight from it, so the
// outputs are registered and hold steady while the consumer stalls.
//   clk_i, arst_i : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (drops every entry)
//   push_i        : write push_data_i at the tail
//   pop_i         : drop the head entry (ignored when empty)
//   valid_o       : FIFO non-empty
//   data_o        : head entry
//   count_o       : number of stored entries
module fpu_res_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign pop_en  = pop_i && (cnt_q != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_en = push_i && ((cnt_q != CntW'(Depth)) || pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_en, pop_en})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (push_en && !clr_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: steers ops to a fixed-latency pipelined path or to an
// iterative div/sqrt unit, collects results in issue order into a result FIFO
// and presents them on a write-back handshake.
//   clk_i, arst_i          : clock, asynchronous active-low reset
//   flush_i                : drop everything in flight or buffered
//   req_valid_i/ready_o    : op handshake; req_is_div_i selects div/sqrt class, req_tag_i tag
//   pipe_issue_o           : start op on pipelined path
//   pipe_res_i             : {fflags,data} from pipe, PIPE_LAT cycles after issue
//   div_start_o/kill_o     : start / abort the div unit
//   div_done_i, div_res_i  : div result pulse and {fflags,data}
//   wb_valid_o/ready_i     : write-back handshake; wb_tag_o/data_o/fflags_o head entry
//   busy_o                 : any op in flight or buffered
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT  = 3,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned XLEN      = 64
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_is_div_i,
  input  logic [TAG_W-1:0]        req_tag_i,
  output logic                    pipe_issue_o,
  input  logic [XLEN+FflagsW-1:0] pipe_res_i,
  output logic                    div_start_o,
  output logic                    div_kill_o,
  input  logic                    div_done_i,
  input  logic [XLEN+FflagsW-1:0] div_res_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [TAG_W-1:0]        wb_tag_o,
  output logic [XLEN-1:0]         wb_data_o,
  output logic [FflagsW-1:0]      wb_fflags_o,
  output logic                    busy_o
);

  localparam int unsigned EntryW = TAG_W + FflagsW + XLEN;
  localparam int unsigned CntW   = $clog2(RES_DEPTH + 1);
  localparam int unsigned OccW   = $clog2(RES_DEPTH + PIPE_LAT + 1);

  fpu_state_e state_q, state_d;

  // Held low through reset and for the first edge after release, so the
  // controller starts accepting ops only once reset is synchronously gone.
  logic active_q;

  logic [PIPE_LAT-1:0] sr_vld_q, sr_vld_d;
  logic [TAG_W-1:0]    sr_tag_q [PIPE_LAT];
  logic [TAG_W-1:0]    div_tag_q;

  logic              tail_vld;
  logic [TAG_W-1:0]  tail_tag;
  logic [OccW-1:0]   inflight;
  logic [OccW-1:0]   occ;
  logic              room;
  logic              pipe_busy;
  logic              ready_ok;
  logic              accept;

  logic              fifo_push;
  logic [EntryW-1:0] fifo_wdata;
  logic              fifo_valid;
  logic [EntryW-1:0] fifo_rdata;
  logic [CntW-1:0]   fifo_cnt;

  // Occupancy counts pipe ops still in the shift register as well as buffered
  // results, so every pipe result is guaranteed a FIFO slot when it returns.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(PIPE_LAT); i++) inflight = inflight + OccW'(sr_vld_q[i]);
  end

  assign occ       = OccW'(fifo_cnt) + inflight;
  assign room      = (occ < OccW'(RES_DEPTH));
  assign pipe_busy = |sr_vld_q;
  assign tail_vld  = sr_vld_q[PIPE_LAT-1];
  assign tail_tag  = sr_tag_q[PIPE_LAT-1];

  // A div op waits until the pipe drains, so its result cannot overtake
  // older pipe results.
  assign ready_ok = active_q && !flush_i && (state_q == StIdle) && room &&
                    (!req_is_div_i || !pipe_busy);
  assign accept   = req_valid_i && ready_ok;

  always_comb begin
    state_d      = state_q;
    req_ready_o  = ready_ok;
    pipe_issue_o = 1'b0;
    div_start_o  = 1'b0;
    div_kill_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_is_div_i) begin
            div_start_o = 1'b1;
            state_d     = StDivRun;
          end else begin
            pipe_issue_o = 1'b1;
          end
        end
      end
      StDivRun: begin
        if (div_done_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d    = StIdle;
      div_kill_o = (state_q == StDivRun);
    end
  end

  always_comb begin
    sr_vld_d    = '0;
    sr_vld_d[0] = pipe_issue_o;
    for (int i = 1; i < int'(PIPE_LAT); i++) sr_vld_d[i] = sr_vld_q[i-1];
    if (flush_i) sr_vld_d = '0;
  end

  // Pipe tail and div completion never coincide: a div only runs with the pipe empty.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    if (!flush_i) begin
      if (tail_vld) begin
        fifo_push  = 1'b1;
        fifo_wdata = {tail_tag, pipe_res_i};
      end else if ((state_q == StDivRun) && div_done_i) begin
        fifo_push  = 1'b1;
        fifo_wdata = {div_tag_q, div_res_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q   <= StIdle;
      active_q  <= 1'b0;
      sr_vld_q  <= '0;
      div_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      sr_vld_q <= sr_vld_d;
      if (div_start_o) div_tag_q <= req_tag_i;
    end
  end

  // Tags shift every cycle; only the matching valid bit gives them meaning.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) sr_tag_q[i] <= '0;
    end else begin
      sr_tag_q[0] <= req_tag_i;
      for (int i = 1; i < int'(PIPE_LAT); i++) sr_tag_q[i] <= sr_tag_q[i-1];
    end
  end

  fpu_res_fifo #(
    .Depth (RES_DEPTH),
    .Width (EntryW)
  ) u_res_fifo (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .clr_i       (flush_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (wb_ready_i),
    .valid_o     (fifo_valid),
    .data_o      (fifo_rdata),
    .count_o     (fifo_cnt)
  );

  assign wb_valid_o = fifo_valid;
  assign {wb_tag_o, wb_fflags_o, wb_data_o} = fifo_rdata;
  assign busy_o = (state_q == StDivRun) || (occ != '0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

  localparam int PL    = 3;
  localparam int RD    = 4;
  localparam int TW    = 5;
  localparam int XL    = 64;
  localparam int RW    = XL + 5;
  localparam int NEVER = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_is_div = 1'b0;
  logic [TW-1:0] req_tag = '0;
  logic          pipe_issue;
  logic [RW-1:0] pipe_res = '0;
  logic          div_start;
  logic          div_kill;
  logic          div_done = 1'b0;
  logic [RW-1:0] div_res = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [TW-1:0] wb_tag;
  logic [XL-1:0] wb_data;
  logic [4:0]    wb_fflags;
  logic          busy;

  fpu_issue_ctrl #(
    .PIPE_LAT  (PL),
    .RES_DEPTH (RD),
    .TAG_W     (TW),
    .XLEN      (XL)
  ) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_is_div_i (req_is_div),
    .req_tag_i    (req_tag),
    .pipe_issue_o (pipe_issue),
    .pipe_res_i   (pipe_res),
    .div_start_o  (div_start),
    .div_kill_o   (div_kill),
    .div_done_i   (div_done),
    .div_res_i    (div_res),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_tag_o     (wb_tag),
    .wb_data_o    (wb_data),
    .wb_fflags_o  (wb_fflags),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accepted op not yet written back, in issue order,
  // with the first cycle it may appear on the write-back port.
  typedef struct {
    logic [TW-1:0] tag;
    logic [RW-1:0] res;
    int            rdy;
  } exp_t;

  exp_t          exp_q[$];
  int            inflight_q[$];
  logic [RW-1:0] pipe_sched[int];
  bit            div_busy = 1'b0;
  bit            div_busy_a = 1'b0;
  bit            active_m = 1'b0;
  logic [RW-1:0] div_data_m = '0;
  logic [RW-1:0] req_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_res();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[RW-1:0];
  endfunction

  // Pipelined-unit stand-in: returns each issued op's result exactly PL cycles later.
  initial forever begin
    @(negedge clk);
    if (pipe_sched.exists(cyc)) begin
      pipe_res = pipe_sched[cyc];
      pipe_sched.delete(cyc);
    end else begin
      pipe_res = rand_res();
    end
  end

  // Control-output checks and scoreboard push on accept.
  initial begin
    exp_t e;
    bit   exp_ready, acc;
    forever begin
      @(negedge clk);
      #2;
      div_busy_a = div_busy;
      if (!arst) begin
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_pipe_issue", 128'(pipe_issue), 128'(0));
        chk("rst_div_start", 128'(div_start), 128'(0));
        chk("rst_div_kill", 128'(div_kill), 128'(0));
        chk("rst_wb_valid", 128'(wb_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_wb_tag", 128'(wb_tag), 128'(0));
        chk("rst_wb_data", 128'(wb_data), 128'(0));
        chk("rst_wb_fflags", 128'(wb_fflags), 128'(0));
      end else begin
        while (inflight_q.size() > 0 && inflight_q[0] < cyc) void'(inflight_q.pop_front());
        exp_ready = active_m && !flush && !div_busy && (exp_q.size() < RD) &&
                    (!req_is_div || inflight_q.size() == 0);
        acc = req_valid && exp_ready;
        chk("req_ready", 128'(req_ready), 128'(exp_ready));
        chk("pipe_issue", 128'(pipe_issue), 128'(acc && !req_is_div));
        chk("div_start", 128'(div_start), 128'(acc && req_is_div));
        chk("div_kill", 128'(div_kill), 128'(flush && div_busy));
        chk("busy", 128'(busy), 128'(div_busy || exp_q.size() > 0));
        chk("wb_valid", 128'(wb_valid), 128'(exp_q.size() > 0 && exp_q[0].rdy <= cyc));
        if (acc) begin
          e.tag = req_tag;
          e.res = req_data;
          if (req_is_div) begin
            e.rdy      = NEVER;
            div_busy   = 1'b1;
            div_data_m = req_data;
          end else begin
            e.rdy = cyc + PL + 1;
            pipe_sched[cyc + PL] = req_data;
            inflight_q.push_back(cyc + PL);
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  // Write-back monitor: pops and compares on every handshake; applies div
  // completion, flush and reset to the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!arst) begin
        exp_q.delete();
        inflight_q.delete();
        div_busy = 1'b0;
        active_m = 1'b0;
      end else begin
        if (wb_valid && wb_ready) begin
          if (exp_q.size() == 0 || exp_q[0].rdy > cyc) begin
            chk("wb_unexpected_pop", 128'(1), 128'(0));
          end else begin
            e = exp_q.pop_front();
            chk("wb_tag", 128'(wb_tag), 128'(e.tag));
            chk("wb_data", 128'(wb_data), 128'(e.res[XL-1:0]));
            chk("wb_fflags", 128'(wb_fflags), 128'(e.res[RW-1:XL]));
          end
        end
        if (div_busy_a && div_done && !flush && exp_q.size() > 0) begin
          e = exp_q.pop_back();
          e.rdy = cyc + 1;
          exp_q.push_back(e);
          div_busy = 1'b0;
        end
        if (flush) begin
          exp_q.delete();
          inflight_q.delete();
          div_busy = 1'b0;
        end
        active_m = 1'b1;
      end
    end
  end

  task automatic drive(input bit v, input bit d, input logic [TW-1:0] t, input bit fl,
                       input bit wr, input bit dn, input logic [RW-1:0] data);
    @(negedge clk);
    req_valid  = v;
    req_is_div = d;
    req_tag    = t;
    flush      = fl;
    wb_ready   = wr;
    div_done   = dn;
    req_data   = data;
    div_res    = dn ? div_data_m : rand_res();
  endtask

  task automatic idle(input int n, input bit wr);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, wr, 1'b0, rand_res());
  endtask

  initial begin
    bit v, d, fl, wr, dn;
    #1 arst = 1'b0;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    idle(2, 1'b1);

    // Single pipe op, tag 3, data 0x4000: write-back 4 cycles after accept.
    drive(1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 69'h4000);
    idle(6, 1'b1);

    // Back-to-back pipe ops with write-back stalled: only RD accepted.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, TW'(8 + i), 1'b0, 1'b0, 1'b0, rand_res());
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Pipe op tag 1 then div tag 2: div waits for the pipe to drain.
    drive(1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, rand_res());
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, rand_res());
    idle(3, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, '0);
    idle(5, 1'b1);

    // Div killed by flush five cycles later; the late done is ignored.
    drive(1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, rand_res());
    idle(4, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
    idle(3, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, '0);
    idle(5, 1'b1);

    // Flush coincident with div done discards the result.
    drive(1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, rand_res());
    idle(3, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, '0);
    idle(3, 1'b1);

    // Reset with three buffered results, then a fresh op.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, TW'(20 + i), 1'b0, 1'b0, 1'b0, rand_res());
    idle(5, 1'b0);
    @(negedge clk);
    arst = 1'b0;
    req_valid = 1'b0;
    idle(2, 1'b0);
    @(negedge clk);
    arst = 1'b1;
    idle(1, 1'b1);
    drive(1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 69'h4000);
    idle(6, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      v  = $urandom_range(0, 99) < 60;
      d  = $urandom_range(0, 99) < 20;
      fl = $urandom_range(0, 99) < 2;
      wr = $urandom_range(0, 99) < 65;
      dn = div_busy ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 3);
      drive(v, d, TW'($urandom), fl, wr, dn, rand_res());
    end

    // Drain, bounded.
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !div_busy) break;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1, div_busy, rand_res());
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    idle(2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 3, meaning fixed latency in cycles of the pipelined FMA/convert path.
REQ-002 SHALL have parameter RES_DEPTH, default 4, meaning result-FIFO entries (power of two, >=2).
REQ-003 SHALL have parameters TAG_W, default 5, meaning instruction tag width; XLEN, default 64, meaning result width.
REQ-004 SHALL have ports:
  clk_i  in  1  clock, all state on rising edge;
  arst_i  in  1  asynchronous, active-low reset;
  flush_i  in  1  pipeline flush;
  req_valid_i  in  1  FPU op offered;
  req_ready_o  out  1  op accepted when valid&ready;
  req_is_div_i  in  1  op is div/sqrt class;
  req_tag_i  in  TAG_W  op tag;
  pipe_issue_o  out  1  start op on pipelined path;
  pipe_res_i  in  XLEN+5  {fflags,data} from pipe, PIPE_LAT cycles after issue;
  div_start_o  out  1  start iterative div/sqrt unit;
  div_kill_o  out  1  abort div unit;
  div_done_i  in  1  div result valid (one-cycle pulse);
  div_res_i  in  XLEN+5  {fflags,data} from div unit;
  wb_valid_o  out  1  write-back entry valid;
  wb_ready_i  in  1  write-back accepts;
  wb_tag_o  out  TAG_W  entry tag;
  wb_data_o  out  XLEN  entry data;
  wb_fflags_o  out  5  entry exception flags;
  busy_o  out  1  any op in flight or buffered.

Function
REQ-005 SHALL implement FSM states IDLE and DIV_RUN.
REQ-006 SHALL define occ = FIFO count + pipe ops in flight; results always return in issue order.
REQ-007 In IDLE, non-div request: req_ready_o=1 iff occ<RES_DEPTH and flush_i=0; on accept pulse pipe_issue_o same cycle, push {valid,tag} into PIPE_LAT-deep shift register.
REQ-008 In IDLE, div request: req_ready_o=1 iff no pipe op in flight, occ<RES_DEPTH, flush_i=0; on accept pulse div_start_o, latch tag, go DIV_RUN.
REQ-009 In DIV_RUN req_ready_o SHALL be 0; on div_done_i write {tag,div_res_i} into FIFO and return to IDLE next cycle.
REQ-010 When shift-register tail valid, SHALL write {tail tag,pipe_res_i} into FIFO that cycle; credit rule guarantees FIFO never overflows.
REQ-011 wb_valid_o SHALL equal FIFO non-empty; head pops on wb_valid_o&wb_ready_i; outputs driven from FIFO head (registered storage), data stable while stalled.
REQ-012 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo RES_DEPTH.
REQ-013 Accept-to-wb_valid_o latency SHALL be PIPE_LAT+1 cycles for pipe ops, div_done_i+1 for div ops, with empty FIFO.
REQ-014 flush_i SHALL, in that cycle, force req_ready_o=0, and next edge clear FIFO, all shift-register valids and FSM to IDLE; pulse div_kill_o for one cycle if in DIV_RUN.
REQ-015 flush_i coincident with div_done_i or pipe tail SHALL discard the result.
REQ-016 busy_o SHALL be 1 when state=DIV_RUN or occ>0.

Reset
REQ-017 On arst_i low: state=IDLE, FIFO empty, shift valids 0; req_ready_o, pipe_issue_o, div_start_o, div_kill_o, wb_valid_o, busy_o =0; wb_tag_o/wb_data_o/wb_fflags_o =0.
REQ-018 Reset mid-operation SHALL drop all ops with no kill pulse; release synchronous to clk_i.

Structure
REQ-019 FSM state enum and fflags width constant (5) SHALL live in the shared core package.
REQ-020 Result FIFO SHALL be one sub-module, fpu_res_fifo (parameterised depth/width, registered output).

Verification
REQ-021 Non-div op tag 3, wb_ready_i=1, pipe_res_i data 0x4000 -> pipe_issue_o at cycle 0, wb_valid_o tag 3 data 0x4000 at cycle 4.
REQ-022 Five back-to-back non-div ops, wb_ready_i=0 -> four accepted, req_ready_o=0 on fifth until one pop.
REQ-023 Non-div tag 1 then div tag 2 next cycle -> div held until tag 1 leaves shift register; write-back order 1,2.
REQ-024 Div started, flush_i at cycle 5 -> div_kill_o one pulse cycle 5, later div_done_i ignored, wb_valid_o stays 0.
REQ-025 flush_i and div_done_i same cycle -> no entry written, state IDLE, busy_o=0 next cycle.
REQ-026 arst_i low with 3 entries buffered -> all outputs 0 immediately, first op after release behaves as REQ-021.
